// File: rtl/fa_result_checker.sv
// fa_result_checker: scoreboard for a WIDTH-bit full adder.
// Operand vectors are queued in an in-order FIFO. Each adder result pops the
// head entry and is compared with the golden sum a+b+cin, computed WIDTH+1
// bits wide. Pass/fail counters saturate at their maximum value.
// Optional macro FA_CHECK_CAPTURE_EN builds registers that hold the first
// failing vector of a session. Without it, the fail_* ports are tied to 0.
// state_dbg exposes the FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module fa_result_checker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             sim_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             in_3,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] out_1,
  input  logic             out_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic             proto_err,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [WIDTH-1:0] fail_in_1,
  output logic [WIDTH-1:0] fail_in_2,
  output logic             fail_in_3,
  output logic [WIDTH:0]   fail_got,
  output logic [1:0]       state_dbg
);
  // Handshake: in_valid and res_valid are single-cycle, no-backpressure
  // strobes. Each cycle in which one of them is high is one transfer. The
  // checker never stalls the adder side, so it has no ready signal. Faults
  // are reported through proto_err instead.

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic             mismatch_q, mismatch_d, proto_err_q, proto_err_d;

  logic             sess_clear, empty, full, push_req, pop_req, bypass;
  logic             do_push, do_pop, overflow, underflow, cmp_valid, cmp_equal;
  logic [EW-1:0]    in_entry, cmp_entry;
  logic [WIDTH:0]   exp_sum, got_sum;

  // FSM next state. start clears the session from IDLE or DONE. stop beats start in RUN.
  always_comb begin
    state_d    = state_q;
    sess_clear = 1'b0;
    case (state_q)
      S_IDLE:  if (start) begin state_d = S_RUN; sess_clear = 1'b1; end
      S_RUN:   if (stop) state_d = S_DRAIN;
      S_DRAIN: if (empty && !res_valid) state_d = S_DONE;
      S_DONE:  if (start) begin state_d = S_RUN; sess_clear = 1'b1; end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO status and compare decode. A push and a pop into an empty FIFO bypass the storage.
  always_comb begin
    in_entry  = {in_1, in_2, in_3};
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_req  = in_valid && (state_q == S_RUN);
    pop_req   = res_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
    bypass    = push_req && pop_req && empty;
    do_pop    = pop_req && !empty;
    do_push   = push_req && !bypass && (!full || pop_req);
    overflow  = push_req && full && !pop_req;
    underflow = pop_req && empty && !push_req;
    cmp_valid = bypass || do_pop;
    cmp_entry = bypass ? in_entry : mem_q[rd_ptr_q[AW-1:0]];
    exp_sum   = {1'b0, cmp_entry[EW-1 -: WIDTH]} + {1'b0, cmp_entry[WIDTH:1]}
              + {{WIDTH{1'b0}}, cmp_entry[0]};
    got_sum   = {out_2, out_1};
    cmp_equal = (exp_sum == got_sum);
  end

  // Datapath next state: FIFO storage, pointers, saturating counters, error flags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    proto_err_d = proto_err_q;
    mismatch_d  = 1'b0;
    if (sess_clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      proto_err_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = in_entry;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (overflow || underflow) proto_err_d = 1'b1;
      if (cmp_valid) begin
        if (cmp_equal) begin
          if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
        end else begin
          if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
          mismatch_d = 1'b1;
        end
      end
    end
  end

  // State registers. Reset discards every queued entry and skips any compare in that cycle.
  always_ff @(posedge sim_clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      mismatch_q  <= mismatch_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef FA_CHECK_CAPTURE_EN
  logic [WIDTH-1:0] cap_in_1_q, cap_in_1_d, cap_in_2_q, cap_in_2_d;
  logic             cap_in_3_q, cap_in_3_d;
  logic [WIDTH:0]   cap_got_q, cap_got_d;

  // Latch only the first failing vector of a session. Later failures leave it untouched.
  always_comb begin
    cap_in_1_d = cap_in_1_q;
    cap_in_2_d = cap_in_2_q;
    cap_in_3_d = cap_in_3_q;
    cap_got_d  = cap_got_q;
    if (sess_clear) begin
      cap_in_1_d = '0;
      cap_in_2_d = '0;
      cap_in_3_d = 1'b0;
      cap_got_d  = '0;
    end else if (cmp_valid && !cmp_equal && (fail_cnt_q == '0)) begin
      cap_in_1_d = cmp_entry[EW-1 -: WIDTH];
      cap_in_2_d = cmp_entry[WIDTH:1];
      cap_in_3_d = cmp_entry[0];
      cap_got_d  = got_sum;
    end
  end

  // Capture registers, cleared by reset.
  always_ff @(posedge sim_clk) begin
    if (!reset) begin
      cap_in_1_q <= '0;
      cap_in_2_q <= '0;
      cap_in_3_q <= 1'b0;
      cap_got_q  <= '0;
    end else begin
      cap_in_1_q <= cap_in_1_d;
      cap_in_2_q <= cap_in_2_d;
      cap_in_3_q <= cap_in_3_d;
      cap_got_q  <= cap_got_d;
    end
  end

  assign fail_in_1 = cap_in_1_q;
  assign fail_in_2 = cap_in_2_q;
  assign fail_in_3 = cap_in_3_q;
  assign fail_got  = cap_got_q;
`else
  assign fail_in_1 = '0;
  assign fail_in_2 = '0;
  assign fail_in_3 = 1'b0;
  assign fail_got  = '0;
`endif

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (fail_cnt_q == '0) && !proto_err_q;
  assign mismatch   = mismatch_q;
  assign proto_err  = proto_err_q;
  assign pass_count = pass_cnt_q;
  assign fail_count = fail_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/fa_result_checker.md
Name: fa_result_checker

Overview:
- Response-side counterpart to the adder stimulus stream. It consumes the operand vectors driven into the WIDTH-bit full adder and the adder's sum/carry results.
- Operands are buffered in a small in-order FIFO until the matching result arrives. Each result is checked against a golden sum, and pass/fail counts are kept.
- Sits beside the adder under test, so a bench or on-board harness reads a single done/pass verdict instead of scanning the monitor log.

Parameters:
- WIDTH, 4: operand and sum width.
- DEPTH, 4: operand FIFO entries (power of two, at least 2).
- CNT_W, 16: width of the pass/fail counters.

Ports:
- sim_clk, input, 1: clock, all state on rising edge.
- reset, input, 1: synchronous active-low reset.
- start, input, 1: begin a check session; sampled in IDLE or DONE.
- stop, input, 1: end the session; sampled in RUN.
- in_valid, input, 1: operand vector present this cycle.
- in_1, input, WIDTH: operand A.
- in_2, input, WIDTH: operand B.
- in_3, input, 1: carry-in.
- res_valid, input, 1: adder result present this cycle.
- out_1, input, WIDTH: adder sum.
- out_2, input, 1: adder carry-out.
- busy, output, 1: high in RUN or DRAIN.
- done, output, 1: high in DONE.
- pass, output, 1: high in DONE when fail_count==0 and no protocol error occurred.
- mismatch, output, 1: one-cycle pulse on a failing compare.
- proto_err, output, 1: sticky; set on FIFO overflow or underflow.
- pass_count, output, CNT_W: matching results.
- fail_count, output, CNT_W: mismatching results.
- fail_in_1, output, WIDTH: A of the first failing vector (see Optional Feature).
- fail_in_2, output, WIDTH: B of the first failing vector.
- fail_in_3, output, 1: carry-in of the first failing vector.
- fail_got, output, WIDTH+1: {out_2,out_1} of the first failing vector.

Behaviour:
- Reset (reset==0 at a sim_clk edge):
  - State goes to IDLE and the FIFO empties.
  - All outputs are 0, including counters, proto_err and the fail_* capture registers.
  - Reset mid-session discards every in-flight entry; no compare is performed that cycle.
- States and transitions:
  - IDLE: start moves to RUN. In the same edge, counters, proto_err, the capture registers and the FIFO are cleared.
  - RUN: stop moves to DRAIN. If stop and start are both high, stop wins.
  - DRAIN: moves to DONE on the cycle the FIFO is empty and res_valid==0.
  - DONE: holds all results. start re-enters RUN with the same clears as from IDLE.
- Push: in_valid in RUN writes {in_1,in_2,in_3} to the FIFO. in_valid is ignored in IDLE, DRAIN and DONE.
- Pop and compare: res_valid in RUN or DRAIN pops the head entry.
  - exp = in_1 + in_2 + in_3, computed WIDTH+1 bits wide with no truncation.
  - got = {out_2,out_1}.
  - Equal: pass_count increments. Different: fail_count increments and mismatch pulses on the next cycle.
- Compare latency: the registered compare result, counter update and mismatch pulse appear 1 cycle after res_valid.
- Simultaneous push and pop:
  - Allowed at any occupancy, including empty. When empty, the pushed entry bypasses the FIFO and is compared immediately.
  - When full, the push is accepted because the pop frees a slot.
- Overflow (push while full with no pop): the entry is dropped, proto_err is set, and the FIFO contents are unchanged.
- Underflow (res_valid while empty with no same-cycle push): no count changes, proto_err is set.
- Counter saturation: both counters saturate at 2^CNT_W-1 and never wrap.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full and empty are distinguished by the MSB.
- pass is combinational from state, fail_count and proto_err.

Optional Feature:
- Macro: FA_CHECK_CAPTURE_EN.
- Defined:
  - On the first mismatch of a session (fail_count==0 before the increment), fail_in_1/2/3 and fail_got latch the failing entry and result.
  - Later mismatches do not overwrite them. They are cleared by start and by reset.
- Undefined: the capture registers are not built, and the fail_* ports are tied to 0.

Test Plan:
- Pass stream:
  - Stimulus: reset low 2 cycles, start, then vectors i=9,18,27,36 with {in_3,in_2,in_1}=i[8:0] and a correct adder response 1 cycle later each; then stop.
  - Required: pass_count==4, fail_count==0, done==1, pass==1, proto_err==0.
- Single fault:
  - Stimulus: vector in_1=4'b1001, in_2=4'b0111, in_3=1 answered with out_1=4'b0001, out_2=0.
  - Required: mismatch pulses once, fail_count==1, pass==0.
  - With FA_CHECK_CAPTURE_EN: fail_in_1=1001, fail_in_2=0111, fail_in_3=1, fail_got=5'b00001.
- Buffering:
  - Stimulus: DEPTH=4; push 4 vectors with no results, then 4 correct results back-to-back.
  - Required: proto_err==0, pass_count==4, and the FIFO empties so DRAIN moves to DONE.
- Overflow and underflow:
  - Stimulus A: a fifth push while full. Required: proto_err==1 and the entry is dropped.
  - Stimulus B (after a new session): res_valid while empty. Required: proto_err==1 and counts unchanged.
- Reset mid-session:
  - Stimulus: reset low in RUN with 3 entries queued.
  - Required: next cycle state IDLE, all outputs 0, FIFO empty. A subsequent start and one correct vector give pass_count==1.
- Boundary sum:
  - Stimulus: in_1=4'b1111, in_2=4'b1111, in_3=1, out_1=4'b1111, out_2=1.
  - Required: counted as pass, confirming exp=31 with no truncation.
